// File: rtl/reg_map_pkg.sv
// Shared register addresses, power-down codes and boot sequencer states for
// the register_map front end.
package reg_map_pkg;

   localparam logic [7:0] ADDR_POWER_DOWN = 8'h00;
   localparam logic [7:0] ADDR_STATUS     = 8'h10;
   localparam logic [7:0] ADDR_TX_CTRL    = 8'h34;
   localparam logic [7:0] ADDR_RX_PACKETS = 8'h48;
   localparam logic [7:0] ADDR_SERDES     = 8'h52;
   localparam logic [7:0] ADDR_AUDIO      = 8'h68;

   localparam int STATUS_PLL_LOCKED_BIT = 7;

   localparam logic [7:0] PD_PLL_ONLY = 8'h74;
   localparam logic [7:0] PD_NONE     = 8'h00;
   localparam logic [7:0] PD_MASTER   = 8'h80;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PD_PLL,
      ST_SETTLE,
      ST_POLL_RD,
      ST_POLL_WAIT,
      ST_PD_ALL,
      ST_CFG_TX,
      ST_CFG_SERDES,
      ST_CFG_AUDIO,
      ST_FAIL_WR,
      ST_DONE,
      ST_FAIL,
      ST_VERIFY_TX,
      ST_VERIFY_SERDES,
      ST_VERIFY_AUDIO
   } boot_state_t;

   // States in which the external host owns the register_map bus.
   function automatic logic is_host_state(boot_state_t s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL);
   endfunction

endpackage

// File: rtl/reg_map_bus_mux.sv
// Combinational host/sequencer mux onto the register_map bus; the host is
// stalled (host_busy_o) whenever it does not own the bus.
module reg_map_bus_mux #(
   parameter int NB_DATA = 8,
   parameter int NB_ADDR = 8
) (
   input  logic               host_phase_i,
   input  logic               start_i,
   input  logic               host_wr_req_i,
   input  logic               host_rd_req_i,
   input  logic [NB_ADDR-1:0] host_addr_i,
   input  logic [NB_DATA-1:0] host_wdata_i,
   input  logic               seq_wr_req_i,
   input  logic               seq_rd_req_i,
   input  logic [NB_ADDR-1:0] seq_addr_i,
   input  logic [NB_DATA-1:0] seq_wdata_i,
   output logic               rm_wr_req_o,
   output logic               rm_rd_req_o,
   output logic [NB_ADDR-1:0] rm_addr_o,
   output logic [NB_DATA-1:0] rm_wdata_o,
   output logic               host_busy_o
);

   logic host_grant;

   // A start pulse steals the bus even in an idle state so the first script
   // write is never raced by a host access.
   assign host_grant  = host_phase_i & ~start_i;
   assign host_busy_o = ~host_grant;

   assign rm_wr_req_o = host_grant ? host_wr_req_i : seq_wr_req_i;
   assign rm_rd_req_o = host_grant ? host_rd_req_i : seq_rd_req_i;
   assign rm_addr_o   = host_grant ? host_addr_i   : seq_addr_i;
   assign rm_wdata_o  = host_grant ? host_wdata_i  : seq_wdata_i;

endmodule

// File: rtl/reg_map_boot_ctrl.sv
// Boot sequencer and bus arbiter in front of register_map.
// Define BOOT_READBACK_EN to verify every configuration write with a readback.
module reg_map_boot_ctrl
   import reg_map_pkg::*;
#(
   parameter int               NB_DATA       = 8,
   parameter int               NB_ADDR       = 8,
   parameter int               SETTLE_CYCLES = 32,
   parameter int               POLL_INTERVAL = 16,
   parameter int               LOCK_TIMEOUT  = 64,
   parameter logic [NB_DATA-1:0] TX_CTRL_CFG = 8'hF4,
   parameter logic [NB_DATA-1:0] SERDES_CFG  = 8'hA8,
   parameter logic [NB_DATA-1:0] AUDIO_CFG   = 8'hF0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               host_wr_req,
   input  logic               host_rd_req,
   input  logic [NB_ADDR-1:0] host_addr,
   input  logic [NB_DATA-1:0] host_wdata,
   output logic [NB_DATA-1:0] host_rdata,
   output logic               host_busy,
   output logic               rm_wr_req,
   output logic               rm_rd_req,
   output logic [NB_ADDR-1:0] rm_addr,
   output logic [NB_DATA-1:0] rm_wdata,
   input  logic [NB_DATA-1:0] rm_rdata,
   output logic               done,
   output logic               error
);

   localparam int WAIT_MAX = (SETTLE_CYCLES > POLL_INTERVAL) ? SETTLE_CYCLES : POLL_INTERVAL;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam int POLL_W   = $clog2(LOCK_TIMEOUT + 1);

   boot_state_t         state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;

   logic                seq_wr_req;
   logic                seq_rd_req;
   logic [NB_ADDR-1:0]  seq_addr;
   logic [NB_DATA-1:0]  seq_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         poll_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         poll_cnt_q <= poll_cnt_d;
      end
   end

   // wait_cnt_d defaults to zero so it is clear whenever SETTLE/POLL_WAIT is entered.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      poll_cnt_d = poll_cnt_q;
      seq_wr_req = 1'b0;
      seq_rd_req = 1'b0;
      seq_addr   = '0;
      seq_wdata  = '0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
               state_d    = ST_PD_PLL;
               poll_cnt_d = '0;
            end
         end
         ST_PD_PLL: begin
            seq_wr_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_POWER_DOWN);
            seq_wdata  = NB_DATA'(PD_PLL_ONLY);
            poll_cnt_d = '0;
            state_d    = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (wait_cnt_q == WAIT_W'(SETTLE_CYCLES - 1)) state_d = ST_POLL_RD;
            else                                          wait_cnt_d = wait_cnt_q + 1'b1;
         end
         ST_POLL_RD: begin
            seq_rd_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_STATUS);
            if (rm_rdata[STATUS_PLL_LOCKED_BIT]) begin
               state_d = ST_PD_ALL;
            end else if (poll_cnt_q == POLL_W'(LOCK_TIMEOUT - 1)) begin
               state_d = ST_FAIL_WR;
            end else begin
               poll_cnt_d = poll_cnt_q + 1'b1;
               state_d    = ST_POLL_WAIT;
            end
         end
         ST_POLL_WAIT: begin
            if (wait_cnt_q == WAIT_W'(POLL_INTERVAL - 1)) state_d = ST_POLL_RD;
            else                                          wait_cnt_d = wait_cnt_q + 1'b1;
         end
         ST_PD_ALL: begin
            seq_wr_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_POWER_DOWN);
            seq_wdata  = NB_DATA'(PD_NONE);
            state_d    = ST_CFG_TX;
         end
         ST_CFG_TX: begin
            seq_wr_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_TX_CTRL);
            seq_wdata  = TX_CTRL_CFG;
`ifdef BOOT_READBACK_EN
            state_d    = ST_VERIFY_TX;
`else
            state_d    = ST_CFG_SERDES;
`endif
         end
         ST_CFG_SERDES: begin
            seq_wr_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_SERDES);
            seq_wdata  = SERDES_CFG;
`ifdef BOOT_READBACK_EN
            state_d    = ST_VERIFY_SERDES;
`else
            state_d    = ST_CFG_AUDIO;
`endif
         end
         ST_CFG_AUDIO: begin
            seq_wr_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_AUDIO);
            seq_wdata  = AUDIO_CFG;
`ifdef BOOT_READBACK_EN
            state_d    = ST_VERIFY_AUDIO;
`else
            state_d    = ST_DONE;
`endif
         end
`ifdef BOOT_READBACK_EN
         ST_VERIFY_TX: begin
            seq_rd_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_TX_CTRL);
            state_d    = (rm_rdata == TX_CTRL_CFG) ? ST_CFG_SERDES : ST_FAIL_WR;
         end
         ST_VERIFY_SERDES: begin
            seq_rd_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_SERDES);
            state_d    = (rm_rdata == SERDES_CFG) ? ST_CFG_AUDIO : ST_FAIL_WR;
         end
         ST_VERIFY_AUDIO: begin
            seq_rd_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_AUDIO);
            state_d    = (rm_rdata == AUDIO_CFG) ? ST_DONE : ST_FAIL_WR;
         end
`endif
         ST_FAIL_WR: begin
            seq_wr_req = 1'b1;
            seq_addr   = NB_ADDR'(ADDR_POWER_DOWN);
            seq_wdata  = NB_DATA'(PD_MASTER);
            state_d    = ST_FAIL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_FAIL);
   assign host_rdata = rm_rdata;

   reg_map_bus_mux #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR)
   ) u_bus_mux (
      .host_phase_i  (is_host_state(state_q)),
      .start_i       (start),
      .host_wr_req_i (host_wr_req),
      .host_rd_req_i (host_rd_req),
      .host_addr_i   (host_addr),
      .host_wdata_i  (host_wdata),
      .seq_wr_req_i  (seq_wr_req),
      .seq_rd_req_i  (seq_rd_req),
      .seq_addr_i    (seq_addr),
      .seq_wdata_i   (seq_wdata),
      .rm_wr_req_o   (rm_wr_req),
      .rm_rd_req_o   (rm_rd_req),
      .rm_addr_o     (rm_addr),
      .rm_wdata_o    (rm_wdata),
      .host_busy_o   (host_busy)
   );

endmodule

// File: tb/tb_reg_map_boot_ctrl.sv
// Self-checking bench for reg_map_boot_ctrl with a behavioural register map
// and a timing/transaction model derived from the boot script rules.
module tb_reg_map_boot_ctrl;

   localparam int S  = 32;
   localparam int PI = 16;
   localparam int LT = 64;
`ifdef BOOT_READBACK_EN
   localparam int RB = 3;
`else
   localparam int RB = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       host_wr_req;
   logic       host_rd_req;
   logic [7:0] host_addr;
   logic [7:0] host_wdata;
   logic [7:0] host_rdata;
   logic       host_busy;
   logic       rm_wr_req;
   logic       rm_rd_req;
   logic [7:0] rm_addr;
   logic [7:0] rm_wdata;
   logic [7:0] rm_rdata;
   logic       done;
   logic       error;

   always #5 clk = ~clk;

   reg_map_boot_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .host_wr_req (host_wr_req),
      .host_rd_req (host_rd_req),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_rdata  (host_rdata),
      .host_busy   (host_busy),
      .rm_wr_req   (rm_wr_req),
      .rm_rd_req   (rm_rd_req),
      .rm_addr     (rm_addr),
      .rm_wdata    (rm_wdata),
      .rm_rdata    (rm_rdata),
      .done        (done),
      .error       (error)
   );

   // Behavioural register map: status bit 7 reports lock once enough polls were seen.
   logic [7:0]  mem [256];
   int          status_reads;
   int          reads_base = 0;
   int          lock_after = 0;
   bit          corrupt_52 = 1'b0;
   logic [16:0] log_q [$];

   always_comb begin
      rm_rdata = mem[rm_addr];
      if (rm_addr == 8'h10)
         rm_rdata = ((status_reads - reads_base) >= lock_after) ? 8'h80 : 8'h00;
      else if (corrupt_52 && rm_addr == 8'h52)
         rm_rdata = 8'h00;
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         status_reads <= 0;
      end else begin
         if (rm_wr_req) begin
            mem[rm_addr] <= rm_wdata;
            log_q.push_back({1'b0, rm_addr, rm_wdata});
         end
         if (rm_rd_req) begin
            log_q.push_back({1'b1, rm_addr, rm_rdata});
            if (rm_addr == 8'h10) status_reads <= status_reads + 1;
         end
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      reads_base = status_reads;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Edges after the start-sampling edge until done or error is seen.
   task automatic wait_end(output int n);
      n = 0;
      while (!(done || error) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("end_within_bound", 32'(n < 3000), 32'd1);
   endtask

   // Expected write stream: the script in order, or the power-up then master power-down.
   task automatic check_writes(input string tag, input int log0, input bit failed);
      logic [15:0] got [$];
      logic [15:0] exp [$];
      if (failed) exp = '{16'h0074, 16'h0080};
      else        exp = '{16'h0074, 16'h0000, 16'h34F4, 16'h52A8, 16'h68F0};
      for (int i = log0; i < log_q.size(); i++)
         if (!log_q[i][16]) got.push_back(log_q[i][15:0]);
      check({tag, "_nwrites"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("%s_wr%0d", tag, i), 32'(got[i]), 32'(exp[i]));
   endtask

   task automatic run_lock(input int k);
      int n;
      int log0;
      log0       = log_q.size();
      lock_after = k;
      pulse_start();
      wait_end(n);
      $display("txn script lock_after=%0d edges=%0d done=%0b error=%0b", k, n, done, error);
      check("lock_latency", 32'(n), 32'(S + 6 + RB + k * (PI + 1)));
      check("lock_done", 32'(done), 32'd1);
      check("lock_error", 32'(error), 32'd0);
      check("lock_polls", 32'(status_reads - reads_base), 32'(k + 1));
      check("lock_pd_reg", 32'(mem[8'h00]), 32'h00);
      check_writes("lock", log0, 1'b0);
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d, input bit exp_busy);
      @(negedge clk);
      host_wr_req = 1'b1;
      host_addr   = a;
      host_wdata  = d;
      #1;
      $display("txn host_wr addr=%02h data=%02h busy=%0b", a, d, host_busy);
      check("hwr_busy", 32'(host_busy), 32'(exp_busy));
      check("hwr_pass", 32'(rm_wr_req), 32'(!exp_busy));
      @(posedge clk);
      #1;
      host_wr_req = 1'b0;
   endtask

   task automatic host_read(input logic [7:0] a, input logic [7:0] exp_d);
      @(negedge clk);
      host_rd_req = 1'b1;
      host_addr   = a;
      #1;
      $display("txn host_rd addr=%02h data=%02h", a, host_rdata);
      check("hrd_busy", 32'(host_busy), 32'd0);
      check("hrd_data", 32'(host_rdata), 32'(exp_d));
      @(posedge clk);
      #1;
      host_rd_req = 1'b0;
   endtask

   initial begin
      int         n;
      int         log0;
      int         k;
      logic [7:0] a;
      logic [7:0] d;

      reset       = 1'b1;
      start       = 1'b0;
      host_wr_req = 1'b1;
      host_rd_req = 1'b0;
      host_addr   = 8'($urandom_range(0, 255));
      host_wdata  = 8'($urandom_range(0, 255));
      #1;
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_busy", 32'(host_busy), 32'd0);
      check("rst_pass_wr", 32'(rm_wr_req), 32'd1);
      check("rst_pass_addr", 32'(rm_addr), 32'(host_addr));
      check("rst_pass_data", 32'(rm_wdata), 32'(host_wdata));
      repeat (3) @(posedge clk);
      host_wr_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Lock on first poll, then on the fourth poll.
      run_lock(0);
      run_lock(3);

      // Random host traffic while the host owns the bus.
      for (int t = 0; t < 6; t++) begin
         a = 8'($urandom_range(0, 255));
         if (a == 8'h10) a = 8'h11;
         d = 8'($urandom_range(0, 255));
         host_write(a, d, 1'b0);
         host_read(a, d);
      end

      // Host write during SETTLE is stalled; the same write in DONE lands.
      log0       = log_q.size();
      lock_after = 0;
      pulse_start();
      repeat (3) @(posedge clk);
      #1;
      host_write(8'h34, 8'h5A, 1'b1);
      wait_end(n);
      check("settle_done", 32'(done), 32'd1);
      check("settle_tx_reg", 32'(mem[8'h34]), 32'hF4);
      check_writes("settle", log0, 1'b0);
      d = 8'($urandom_range(0, 255));
      host_write(8'h34, d, 1'b0);
      host_read(8'h34, d);

      // Start in the same cycle as a host read in DONE.
      @(negedge clk);
      host_rd_req = 1'b1;
      host_addr   = 8'h34;
      start       = 1'b1;
      reads_base  = status_reads;
      #1;
      $display("txn start_with_host_rd busy=%0b rm_rd=%0b", host_busy, rm_rd_req);
      check("startrd_busy", 32'(host_busy), 32'd1);
      check("startrd_drop", 32'(rm_rd_req), 32'd0);
      @(posedge clk);
      #1;
      start       = 1'b0;
      host_rd_req = 1'b0;
      check("startrd_done_clr", 32'(done), 32'd0);
      wait_end(n);
      check("startrd_latency", 32'(n), 32'(S + 6 + RB));

      // Never locks: exactly LT polls, then master power-down and error.
      log0       = log_q.size();
      lock_after = 100000;
      pulse_start();
      wait_end(n);
      $display("txn script no_lock edges=%0d done=%0b error=%0b", n, done, error);
      check("tmo_latency", 32'(n), 32'(S + 3 + (PI + 1) * (LT - 1)));
      check("tmo_error", 32'(error), 32'd1);
      check("tmo_done", 32'(done), 32'd0);
      check("tmo_polls", 32'(status_reads - reads_base), 32'(LT));
      check("tmo_pd_reg", 32'(mem[8'h00]), 32'h80);
      check_writes("tmo", log0, 1'b1);

      // Asynchronous reset in the middle of a POLL_WAIT gap.
      lock_after = 100000;
      pulse_start();
      repeat (S + 8) @(posedge clk);
      @(negedge clk);
      host_rd_req = 1'b1;
      host_addr   = 8'h34;
      #1;
      check("pw_busy", 32'(host_busy), 32'd1);
      check("pw_rd_drop", 32'(rm_rd_req), 32'd0);
      host_rd_req = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      $display("txn async_reset busy=%0b rm_wr=%0b rm_rd=%0b", host_busy, rm_wr_req, rm_rd_req);
      check("arst_busy", 32'(host_busy), 32'd0);
      check("arst_wr", 32'(rm_wr_req), 32'd0);
      check("arst_rd", 32'(rm_rd_req), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_error", 32'(error), 32'd0);
      host_rd_req = 1'b1;
      #1;
      check("arst_pass_rd", 32'(rm_rd_req), 32'd1);
      host_rd_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      k = $urandom_range(1, 5);
      run_lock(k);

`ifdef BOOT_READBACK_EN
      // SERDES readback returns 0x00 and must abort the script.
      corrupt_52 = 1'b1;
      lock_after = 0;
      pulse_start();
      wait_end(n);
      $display("txn readback_fault edges=%0d done=%0b error=%0b", n, done, error);
      check("rb_error", 32'(error), 32'd1);
      check("rb_done", 32'(done), 32'd0);
      check("rb_latency", 32'(n), 32'(S + 8));
      check("rb_pd_reg", 32'(mem[8'h00]), 32'h80);
      corrupt_52 = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
